stage_if: RTL
=============

STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_0, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port pc_select, input, 2 bits: next-PC select from ID (00 sequential, 01 branch, 10 jr, 11 j/jal).
REQ-005 SHALL have ports pc_b, pc_j, a_id, input, 32 bits each: branch target, jump target and jr register target from ID.
REQ-006 SHALL have port stall, input, 1 bit: ID load-use stall, which holds the IF/ID register.
REQ-007 SHALL have port imem_addr, output, 32 bits: fetch address, word-aligned.
REQ-008 SHALL have port imem_req, output, 1 bit: fetch request.
REQ-009 SHALL have port imem_ack, input, 1 bit: request accepted and imem_rdata valid this cycle.
REQ-010 SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-011 SHALL have ports pc4_id and instr_id, output, 32 bits each: IF/ID register contents (PC+4, instruction).
REQ-012 SHALL have port valid_id, output, 1 bit: IF/ID holds a real instruction; 0 means bubble.

Function
REQ-013 SHALL keep a PC register, an IF/ID register (pc4_id, instr_id, valid_id), a 32-bit hold buffer with its own valid flag, and a 2-bit FSM with states FETCH, WAIT, HOLD and DROP.
REQ-014 SHALL drive imem_addr = PC with bits [1:0] forced to 00, and SHALL assert imem_req in FETCH and WAIT only.
REQ-015 SHALL keep imem_addr stable while imem_req=1 and imem_ack=0.
REQ-016 SHALL treat a request as complete only in a cycle where imem_ack=1; ack in the same cycle as req gives zero wait states.
REQ-017 SHALL define a redirect as pc_select != 00 with stall=0 in the same cycle.
REQ-018 SHALL use these redirect targets: pc_select 01 -> pc_b, 10 -> a_id, 11 -> pc_j.
REQ-019 Redirect priority: on a redirect, PC <= target and the IF/ID register <= bubble (instr_id=0, pc4_id=0, valid_id=0).
REQ-020 Redirect priority: any fetched or held word SHALL be discarded, and the hold buffer cleared.
REQ-021 Redirect next state: a redirect with a request outstanding and no ack this cycle -> DROP; any other redirect -> FETCH.
REQ-022 FETCH/WAIT, ack, no redirect, stall=0: IF/ID <= {PC+4, imem_rdata, 1}; PC <= PC+4; state FETCH.
REQ-023 FETCH/WAIT, ack, no redirect, stall=1: hold buffer <= imem_rdata; PC <= PC+4; IF/ID unchanged; state HOLD.
REQ-024 FETCH/WAIT, no ack: IF/ID <= bubble if stall=0, unchanged if stall=1; state WAIT.
REQ-025 HOLD: imem_req=0; while stall=1 nothing changes.
REQ-026 HOLD: when stall=0, IF/ID <= {PC, hold buffer, 1}, since PC already equals held PC+4; then state FETCH.
REQ-027 DROP: imem_req=0 while awaiting the stale ack; imem_rdata on that ack SHALL be ignored.
REQ-028 DROP: on the stale ack -> FETCH; on a further redirect while in DROP -> PC updates and state stays DROP.
REQ-029 DROP: while waiting, IF/ID <= bubble if stall=0.
REQ-030 With stall=1, IF/ID SHALL never change, regardless of pc_select.
REQ-031 PC+4 SHALL wrap modulo 2^32, so 32'hFFFFFFFC -> 32'h00000000.
REQ-032 SHALL fetch at most one instruction per cycle and have at most one request outstanding.
REQ-033 Fetch-to-ID latency SHALL be 1 cycle after ack.
REQ-034 Redirect penalty SHALL be 1 bubble with zero-wait memory.

Reset
REQ-035 With reset_0=1 at a rising edge, PC SHALL load RESET_PC and state SHALL go to FETCH.
REQ-036 With reset_0=1 at a rising edge, IF/ID SHALL become a bubble (pc4_id=0, instr_id=0, valid_id=0).
REQ-037 With reset_0=1 at a rising edge, the hold buffer SHALL be cleared.
REQ-038 Reset SHALL override stall, redirect and ack in the same cycle.
REQ-039 Reset asserted mid-request SHALL abandon the request; an ack arriving after reset SHALL be taken as the response for RESET_PC.
REQ-040 Outputs SHALL be 0 in the first cycle after reset, except imem_req=1 and imem_addr=RESET_PC.

Verification
REQ-041 Zero-wait ack, pc_select=00, stall=0, words 0x20010005/0x20020003 at 0x0/0x4 -> IF/ID (4, 0x20010005, 1), then (8, 0x20020003, 1).
REQ-042 imem_ack delayed 3 cycles on address 0x4 -> imem_addr held at 0x4 for 4 cycles, 3 bubbles, then (8, word, 1).
REQ-043 stall=1 for 2 cycles during an ack at 0x8 -> IF/ID unchanged 2 cycles, imem_req=0 in HOLD, then (0xC, word@0x8, 1), no refetch.
REQ-044 pc_select=01, pc_b=0x40, with zero-wait memory -> next IF/ID is a bubble, next imem_addr=0x40, then (0x44, word@0x40, 1).
REQ-045 pc_select=10, a_id=0x100, with a pending un-acked fetch at 0x10 -> DROP, stale ack data ignored, next request at 0x100.
REQ-046 reset_0 pulsed while in HOLD with stall=1 -> bubble, PC=RESET_PC, imem_req=1 next cycle; PC wrap at 0xFFFFFFFC -> pc4_id=0x0.

Source files
------------

// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC, the IF/ID pipeline register and a
// one-word hold buffer that absorbs a fetch completing during an ID stall.
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset_0,
  input  logic [1:0]  pc_select,
  input  logic [31:0] pc_b,
  input  logic [31:0] pc_j,
  input  logic [31:0] a_id,
  input  logic        stall,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc4_id,
  output logic [31:0] instr_id,
  output logic        valid_id
);

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        vld;
  } ifid_t;

  localparam ifid_t BUBBLE = '0;

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DROP  = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] target;
  logic [31:0] hold_buf;
  logic        hold_vld;
  logic        redirect;
  ifid_t       ifid;

  always_comb begin
    case (pc_select)
      2'b10:   target = a_id;
      2'b11:   target = pc_j;
      default: target = pc_b;
    endcase
  end

  // A redirect from ID is only real when ID itself is not stalled.
  assign redirect  = (pc_select != 2'b00) && !stall;
  assign pc_inc    = pc + 32'd4;
  assign imem_addr = {pc[31:2], 2'b00};
  assign imem_req  = (state == FETCH) || (state == WAIT);
  assign pc4_id    = ifid.pc4;
  assign instr_id  = ifid.instr;
  assign valid_id  = ifid.vld;

  always_ff @(posedge clock) begin
    if (reset_0) begin
      pc       <= RESET_PC;
      state    <= FETCH;
      ifid     <= BUBBLE;
      hold_buf <= '0;
      hold_vld <= 1'b0;
    end else begin
      case (state)
        FETCH, WAIT: begin
          if (redirect) begin
            pc       <= target;
            ifid     <= BUBBLE;
            hold_buf <= '0;
            hold_vld <= 1'b0;
            // An un-acked request is still in flight; its answer must be eaten.
            state    <= imem_ack ? FETCH : DROP;
          end else if (imem_ack) begin
            pc <= pc_inc;
            if (stall) begin
              hold_buf <= imem_rdata;
              hold_vld <= 1'b1;
              state    <= HOLD;
            end else begin
              ifid  <= '{pc4: pc_inc, instr: imem_rdata, vld: 1'b1};
              state <= FETCH;
            end
          end else begin
            if (!stall) ifid <= BUBBLE;
            state <= WAIT;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc       <= target;
            ifid     <= BUBBLE;
            hold_buf <= '0;
            hold_vld <= 1'b0;
            state    <= FETCH;
          end else if (!stall) begin
            // PC was already advanced when the word was captured.
            ifid     <= '{pc4: pc, instr: hold_buf, vld: hold_vld};
            hold_buf <= '0;
            hold_vld <= 1'b0;
            state    <= FETCH;
          end
        end
        DROP: begin
          if (redirect) begin
            pc    <= target;
            ifid  <= BUBBLE;
            state <= imem_ack ? FETCH : DROP;
          end else begin
            if (!stall) ifid <= BUBBLE;
            if (imem_ack) state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
